// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with registered one-hot grant, tri-state enables and owner data mux.
// Optional ownership time limit enabled with macro BUS_TIMEOUT_EN.
module bus_arbiter_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       gnt,
    output logic [CHANNELS-1:0]       bus_en,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid,
    output logic                      timeout
);

    localparam int PTR_W = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t                state_r, state_nx;
    logic [PTR_W-1:0]      owner_r, owner_nx;
    logic [PTR_W-1:0]      rr_ptr_r, rr_ptr_nx;
    logic [CHANNELS-1:0]   gnt_r, gnt_nx;
    logic [WIDTH-1:0]      data_out_r, data_out_nx;
    logic                  valid_r, valid_nx;
    logic                  timeout_r, timeout_nx;
    logic [PTR_W-1:0]      pick_s;
    logic [PTR_W-1:0]      rr_next_s;
    logic [CHANNELS-1:0]   pick_onehot_s;
    logic                  expire_s;

    // First requester at or above ptr, wrapping past the top channel.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [CHANNELS-1:0] r,
                                                 input logic [PTR_W-1:0]    ptr);
        logic [PTR_W:0] idx;
        logic           found;
        found   = 1'b0;
        rr_pick = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(CHANNELS)) begin
                idx = idx - (PTR_W+1)'(CHANNELS);
            end else begin
                idx = idx;
            end
            if (!found && r[idx[PTR_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[PTR_W-1:0];
            end else begin
                found = found;
            end
        end
    endfunction

    assign pick_s    = rr_pick(req, rr_ptr_r);
    assign rr_next_s = (owner_r == PTR_W'(CHANNELS-1)) ? '0 : owner_r + 1'b1;

    // One-hot decode of the arbitration winner.
    always_comb begin
        pick_onehot_s         = '0;
        pick_onehot_s[pick_s] = 1'b1;
    end

`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt_r, cnt_nx;

    assign expire_s = (cnt_r == 8'(TIMEOUT-1));

    // Ownership age: zero on every entry to GRANT, counts while owned.
    always_comb begin
        if (state_r == GRANT) begin
            cnt_nx = cnt_r + 8'd1;
        end else begin
            cnt_nx = 8'd0;
        end
    end

    // Ownership age register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_nx;
        end
    end
`else
    // Ownership is unlimited; TIMEOUT is at least 2, so this is constant 0.
    assign expire_s = (TIMEOUT == 0);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_nx    = state_r;
        owner_nx    = owner_r;
        rr_ptr_nx   = rr_ptr_r;
        gnt_nx      = gnt_r;
        data_out_nx = data_out_r;
        valid_nx    = valid_r;
        timeout_nx  = 1'b0;
        case (state_r)
            IDLE, TURNAROUND: begin
                data_out_nx = '0;
                valid_nx    = 1'b0;
                if (|req) begin
                    state_nx = GRANT;
                    owner_nx = pick_s;
                    gnt_nx   = pick_onehot_s;
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end
            end
            GRANT: begin
                if (!req[owner_r] || expire_s) begin
                    state_nx    = TURNAROUND;
                    rr_ptr_nx   = rr_next_s;
                    gnt_nx      = '0;
                    data_out_nx = '0;
                    valid_nx    = 1'b0;
                    timeout_nx  = expire_s & req[owner_r];
                end else begin
                    data_out_nx = data_in[int'(owner_r)*WIDTH +: WIDTH];
                    valid_nx    = 1'b1;
                end
            end
            default: begin
                state_nx    = IDLE;
                owner_nx    = '0;
                rr_ptr_nx   = '0;
                gnt_nx      = '0;
                data_out_nx = '0;
                valid_nx    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops ownership immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            gnt_r      <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            owner_r    <= owner_nx;
            rr_ptr_r   <= rr_ptr_nx;
            gnt_r      <= gnt_nx;
            data_out_r <= data_out_nx;
            valid_r    <= valid_nx;
            timeout_r  <= timeout_nx;
        end
    end

    assign gnt      = gnt_r;
    assign bus_en   = gnt_r;
    assign data_out = data_out_r;
    assign valid    = valid_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Randomized and directed bench for bus_arbiter_mux against an ownership-level reference model.
module tb_bus_arbiter_mux;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int TO = 4;

    logic           clk;
    logic           rst_n;
    logic [C-1:0]   req;
    logic [C*W-1:0] data_in;
    logic [C-1:0]   gnt;
    logic [C-1:0]   bus_en;
    logic [W-1:0]   data_out;
    logic           valid;
    logic           timeout;

    int checks;
    int failures;

    // Reference model: who owns the bus, for how long, and where the next search starts.
    int           m_owner;
    int           m_age;
    int           m_rr;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_to;

    bus_arbiter_mux #(.WIDTH(W), .CHANNELS(C), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .bus_en   (bus_en),
        .data_out (data_out),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [C-1:0] m_gnt();
        logic [C-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_rr    = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [C-1:0] r, input logic [C*W-1:0] d);
        bit expire;
        m_to = 1'b0;
        if (m_owner >= 0) begin
`ifdef BUS_TIMEOUT_EN
            expire = (m_age == TO);
`else
            expire = 1'b0;
`endif
            if (!r[m_owner] || expire) begin
                m_to    = expire && r[m_owner];
                m_rr    = (m_owner + 1) % C;
                m_owner = -1;
                m_data  = '0;
                m_valid = 1'b0;
            end else begin
                m_data  = d[m_owner*W +: W];
                m_valid = 1'b1;
                m_age   = m_age + 1;
            end
        end else begin
            m_data  = '0;
            m_valid = 1'b0;
            if (r != '0) begin
                for (int k = C - 1; k >= 0; k--) begin
                    if (r[(m_rr + k) % C]) m_owner = (m_rr + k) % C;
                end
                m_age = 1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(req, data_in);
        @(negedge clk);
        check_eq("gnt", gnt, m_gnt());
        check_eq("bus_en", bus_en, m_gnt());
        check_eq("data_out", data_out, m_data);
        check_eq("valid", valid, m_valid);
        check_eq("timeout", timeout, m_to);
    endtask

    initial begin
        logic [C-1:0] g_hist[1:10];
        logic         t_hist[1:10];
        logic [C-1:0] prev_g;
        int           run;
        int           to_cnt;

        checks   = 0;
        failures = 0;
        model_reset();

        // Reset holds everything at zero even with requests present.
        rst_n   = 1'b0;
        req     = 4'b0101;
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        #23;
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_bus_en", bus_en, 4'b0000);
        check_eq("rst_data", data_out, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("first_gnt", gnt, 4'b0001);
        data_in = {8'h44, 8'h33, 8'h22, 8'hA5};
        tick();
        check_eq("first_data", data_out, 8'hA5);
        check_eq("first_valid", valid, 1'b1);

        // Scenario 1: release, dead cycle, round-robin hand-over.
        req = 4'b0110;
        tick();
        check_eq("s1_dead0", gnt, 4'b0000);
        check_eq("s1_dead0_valid", valid, 1'b0);
        tick();
        check_eq("s1_ch1", gnt, 4'b0010);
        tick();
        check_eq("s1_ch1_data", data_out, 8'h22);
        req = 4'b0100;
        tick();
        check_eq("s1_dead1", gnt, 4'b0000);
        tick();
        check_eq("s1_ch2", gnt, 4'b0100);

        // Scenario 2: idle with pointer at 3, then wrap-around to channel 0.
        req = 4'b0000;
        tick();
        tick();
        check_eq("s2_idle", gnt, 4'b0000);
        req = 4'b1001;
        tick();
        check_eq("s2_ch3", gnt, 4'b1000);
        req = 4'b0001;
        tick();
        check_eq("s2_dead", gnt, 4'b0000);
        req = 4'b1001;
        tick();
        check_eq("s2_wrap", gnt, 4'b0001);

        // Scenario 5: bring pointer to 2, then ch2 and ch1 request for 10 cycles.
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0110;
        for (int i = 1; i <= 10; i++) begin
            tick();
            g_hist[i] = gnt;
            t_hist[i] = timeout;
        end
        run = 0;
        while (run < 10 && g_hist[run+1] == 4'b0100) run++;
        to_cnt = 0;
        for (int i = 1; i <= 10; i++) to_cnt += int'(t_hist[i]);
`ifdef BUS_TIMEOUT_EN
        check_eq("s5_run", run, 4);
        check_eq("s5_pulse", t_hist[5], 1'b1);
        check_eq("s5_dead", g_hist[5], 4'b0000);
        check_eq("s5_next", g_hist[6], 4'b0010);
`else
        check_eq("s5_run", run, 10);
        check_eq("s5_pulses", to_cnt, 0);
`endif

        // Scenario 4: asynchronous reset between edges while a channel owns the bus.
        req = 4'b0100;
        tick();
        tick();
        check_eq("s4_owned", gnt != 4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s4_gnt", gnt, 4'b0000);
        check_eq("s4_valid", valid, 1'b0);
        check_eq("s4_data", data_out, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1100;
        tick();
        check_eq("s4_regrant", gnt, 4'b0100);

        // Scenario 3: slowly-changing random requests with random data.
        prev_g = gnt;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < C; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            data_in = $urandom;
            tick();
            if ((gnt & (gnt - 4'd1)) != 4'b0000) check_eq("s3_onehot", gnt, 4'b0000);
            if (prev_g != 4'b0000 && gnt != 4'b0000 && gnt != prev_g)
                check_eq("s3_no_dead", gnt, 4'b0000);
            prev_g = gnt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter WIDTH, 8, data width per channel; legal range 1..64.
REQ-002 Parameter CHANNELS, 4, number of requesters; legal range 2..16.
REQ-003 Parameter TIMEOUT, 16, maximum ownership cycles; legal range 2..255; used only with BUS_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  CHANNELS  per-channel bus request; bit i belongs to channel i.
REQ-007 data_in  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  CHANNELS  registered one-hot grant; all-zero when no owner.
REQ-009 bus_en  output  CHANNELS  registered tri-state driver enables; always equal to gnt.
REQ-010 data_out  output  WIDTH  registered data from the current owner.
REQ-011 valid  output  1  high while data_out carries owner data.
REQ-012 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and TURNAROUND.
REQ-014 IDLE: no req -> stay; any req bit set -> GRANT, owner chosen by round-robin (REQ-018), gnt visible one cycle after req is sampled.
REQ-015 GRANT: each cycle, data_out <= data_in[owner] and valid=1; gnt holds the owner bit.
REQ-016 GRANT: req[owner]=0 at an edge -> TURNAROUND; gnt, bus_en and valid go 0 and data_out goes 0 on that same edge.
REQ-017 TURNAROUND: exactly one dead cycle with gnt=0; then any req -> GRANT with a new round-robin pick, else -> IDLE.
REQ-018 Round-robin:
  - rr_ptr is a pointer of width clog2(CHANNELS).
  - On release, rr_ptr is set to (owner+1) mod CHANNELS.
  - The search starts at rr_ptr, goes upward and wraps from CHANNELS-1 to 0.
  - The first channel with req set wins.
REQ-019 At most one gnt bit SHALL be high in any cycle; no two bus_en bits are ever high together, and there is never an owner-to-owner transition without a TURNAROUND cycle.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until arbitration; req pulses that are not held until arbitration are not remembered.
REQ-021 A channel that releases and re-requests in TURNAROUND SHALL lose to any other requester, but wins if it is the sole requester.
REQ-022 While valid=0, data_out SHALL be 0.
REQ-023 Requests that are simultaneous at IDLE SHALL be resolved solely by rr_ptr.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force the following, independent of clk:
  - state=IDLE, rr_ptr=0;
  - gnt=0, bus_en=0, data_out=0, valid=0, timeout=0;
  - ownership counter=0.
REQ-025 Reset in mid-GRANT SHALL drop ownership with no TURNAROUND.
  - After release of rst_n, the first edge with req set grants per rr_ptr=0.

Configuration
REQ-026 With macro BUS_TIMEOUT_EN defined:
  - An ownership counter runs during GRANT.
  - On the owner's TIMEOUT-th GRANT cycle, the block SHALL force TURNAROUND at the next edge.
  - The same edge pulses timeout=1 for one cycle and advances rr_ptr as in a normal release.
  - The counter clears on every entry to GRANT.
REQ-027 Without BUS_TIMEOUT_EN, ownership SHALL be unlimited, the counter logic SHALL be absent, and timeout SHALL be tied to 0 (the port is still present).

Verification (CHANNELS=4, WIDTH=8, TIMEOUT=4)
REQ-028 Bench setup: rst_n=0 while req=4'b0101 -> all outputs 0; release rst_n -> next edge gnt=4'b0001.
  - Then data_in ch0=8'hA5 -> data_out=8'hA5 with valid=1 from the following cycle.
REQ-029 Scenario 1: ch0 owns, then drops req while req=4'b0110 -> one cycle with gnt=0, then gnt=4'b0010.
  - ch1 drops -> one dead cycle, then gnt=4'b0100.
REQ-030 Scenario 2: rr_ptr=3 and req=4'b1001 in IDLE -> gnt=4'b1000; after its release with req=4'b1001 held -> gnt=4'b0001 (wrap-around).
REQ-031 Scenario 3: random req patterns for 10000 cycles -> a one-hot-or-zero assertion on gnt holds, bus_en==gnt, and every owner change passes through gnt=0.
REQ-032 Scenario 4: pull rst_n low mid-GRANT, between clock edges -> gnt, valid and data_out are 0 before the next edge.
REQ-033 Scenario 5 (BUS_TIMEOUT_EN): ch2 holds req for 10 cycles with req=4'b0110 -> ch2 gnt for 4 cycles, timeout pulse, dead cycle, then gnt=4'b0010.
  - Without the macro, ch2 holds for all 10 cycles and timeout stays 0.
